// File: rtl/hazard_unit_mc_pkg.sv
// ============================================================================
// Module : hazard_unit_mc_pkg
// Brief  : Shared PC-select codes, RV32I opcodes and operand-use decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_unit_mc_pkg;

    localparam logic [2:0] PC_HOLD  = 3'b000;
    localparam logic [2:0] PC_PLUS4 = 3'b001;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } operand_use_t;

    function automatic operand_use_t decode_use(input logic [6:0] opcode);
        operand_use_t u;
        u = '0;
        case (opcode)
            OPCODE_OP:                              u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            OPCODE_STORE, OPCODE_BRANCH:            u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC:   u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            default:                                u = '0;
        endcase
        return u;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Per-register pending-load bits with same-cycle writeback bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [4:0]      set_rd,
    input  logic            clr_en,
    input  logic [4:0]      clr_rd,
    output logic [NREG-1:0] pending
);

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_reg
            if (g == 0) begin : g_zero
                assign pending[g] = 1'b0;
            end else begin : g_live
                logic r_bit;
                logic w_set;
                logic w_clr;

                assign w_set = set_en && (set_rd == 5'(g));
                assign w_clr = clr_en && (clr_rd == 5'(g));

                // Set wins over a coincident clear: a new load is in flight.
                always_ff @(posedge clk) begin
                    if (rst)        r_bit <= 1'b0;
                    else if (w_set) r_bit <= 1'b1;
                    else if (w_clr) r_bit <= 1'b0;
                end

                assign pending[g] = r_bit & ~w_clr;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// ============================================================================
// Module : hazard_unit_mc
// Brief  : Scoreboarded RAW/WAW stall, redirect flush FSM and stall watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       redirect,
    input  logic [2:0] redirect_pc_sel,
    output logic [2:0] pc_sel,
    output logic       IFID_write,
    output logic       mux_select,
    output logic       kill_IF,
    output logic       kill_DEC,
    output logic       hazard_timeout
);

    localparam int             SCW          = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] C_TIMEOUT    = SCW'(TIMEOUT);
    localparam logic [1:0]     C_FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    logic [NREG-1:0] w_pending;
    operand_use_t    w_use;
    logic            w_ex_load;
    logic            w_rs1_haz;
    logic            w_rs2_haz;
    logic            w_rd_haz;
    logic            w_hazard;
    logic            w_stall;

    flush_state_t    r_state, w_state_next;
    logic [1:0]      r_fcnt, w_fcnt_next;
    logic [SCW-1:0]  r_stall_cnt, w_stall_cnt_next;
    logic            r_timeout;

    hazard_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (ex_mem_read),
        .set_rd  (ex_rd),
        .clr_en  (wb_valid),
        .clr_rd  (wb_rd),
        .pending (w_pending)
    );

    assign w_use     = decode_use(opcode);
    assign w_ex_load = ex_mem_read && (ex_rd != 5'd0);

    // The load still in EX has not reached the scoreboard yet, so match it directly.
    assign w_rs1_haz = w_use.rs1 && (id_rs1 != 5'd0) &&
                       ((w_ex_load && (ex_rd == id_rs1)) || w_pending[id_rs1]);
    assign w_rs2_haz = w_use.rs2 && (id_rs2 != 5'd0) &&
                       ((w_ex_load && (ex_rd == id_rs2)) || w_pending[id_rs2]);
    assign w_rd_haz  = w_use.rd && w_pending[id_rd];
    assign w_hazard  = w_rs1_haz || w_rs2_haz || w_rd_haz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fcnt      <= 2'd0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fcnt      <= w_fcnt_next;
            r_stall_cnt <= w_stall_cnt_next;
            if (w_stall && (w_stall_cnt_next == C_TIMEOUT)) r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        pc_sel       = PC_PLUS4;
        IFID_write   = 1'b1;
        mux_select   = 1'b0;
        kill_IF      = 1'b0;
        kill_DEC     = 1'b0;
        w_stall      = 1'b0;

        if (redirect) begin
            w_state_next = ST_FLUSH;
            w_fcnt_next  = C_FLUSH_LAST;
        end else if (r_state == ST_FLUSH) begin
            if (r_fcnt == 2'd0) w_state_next = ST_IDLE;
            else                w_fcnt_next  = r_fcnt - 2'd1;
        end

        if (rst) begin
            pc_sel     = PC_HOLD;
            IFID_write = 1'b0;
            mux_select = 1'b1;
            kill_IF    = 1'b1;
            kill_DEC   = 1'b1;
        end else if (redirect) begin
            pc_sel     = redirect_pc_sel;
            mux_select = 1'b1;
            kill_IF    = 1'b1;
            kill_DEC   = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            mux_select = 1'b1;
            kill_IF    = 1'b1;
            kill_DEC   = 1'b1;
        end else if (w_hazard) begin
            w_stall    = 1'b1;
            pc_sel     = PC_HOLD;
            IFID_write = 1'b0;
            mux_select = 1'b1;
        end
    end

    assign w_stall_cnt_next = !w_stall                   ? '0 :
                              (r_stall_cnt == C_TIMEOUT) ? r_stall_cnt :
                                                           r_stall_cnt + SCW'(1);

    assign hazard_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
// ============================================================================
// Module : tb_hazard_unit_mc
// Brief  : Scoreboard bench for hazard_unit_mc against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit_mc;

    localparam int FC = 2;
    localparam int TO = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_NONE   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
    logic       ex_mem_read, wb_valid, redirect;
    logic [2:0] redirect_pc_sel;
    logic [2:0] pc_sel;
    logic       IFID_write, mux_select, kill_IF, kill_DEC, hazard_timeout;

    typedef struct packed {
        logic [2:0] pc_sel;
        logic       ifid;
        logic       mux;
        logic       kif;
        logic       kdec;
        logic       to;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Behavioural model: pending set, remaining kill cycles, stall run length.
    bit   m_sb[32];
    int   m_kill = 0;
    int   m_run  = 0;
    bit   m_to   = 1'b0;

    hazard_unit_mc #(
        .NREG         (32),
        .FLUSH_CYCLES (FC),
        .TIMEOUT      (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .redirect        (redirect),
        .redirect_pc_sel (redirect_pc_sel),
        .pc_sel          (pc_sel),
        .IFID_write      (IFID_write),
        .mux_select      (mux_select),
        .kill_IF         (kill_IF),
        .kill_DEC        (kill_DEC),
        .hazard_timeout  (hazard_timeout)
    );

    always #5 clk = ~clk;

    function automatic bit pend(input logic [4:0] r);
        return (r != 0) && m_sb[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit src_haz(input bit used, input logic [4:0] r);
        return used && (r != 0) && ((ex_mem_read && ex_rd == r) || pend(r));
    endfunction

    task automatic step(input bit r, input logic [6:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic [4:0] exd,
                        input bit exm, input bit wbv, input logic [4:0] wbd,
                        input bit rdr, input logic [2:0] rsel);
        out_t e;
        bit   u1, u2, ud, haz, stall;
        rst = r; opcode = op; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        ex_rd = exd; ex_mem_read = exm; wb_valid = wbv; wb_rd = wbd;
        redirect = rdr; redirect_pc_sel = rsel;

        u1 = (op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) || (op == OP_JALR) ||
             (op == OP_STORE) || (op == OP_BRANCH);
        u2 = (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
        ud = (op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) || (op == OP_JALR) ||
             (op == OP_JAL) || (op == OP_LUI) || (op == OP_AUIPC);
        haz = src_haz(u1, s1) || src_haz(u2, s2) || (ud && pend(d));
        stall = 1'b0;

        if (r)                e = '{3'b000, 1'b0, 1'b1, 1'b1, 1'b1, m_to};
        else if (rdr)         e = '{rsel,   1'b1, 1'b1, 1'b1, 1'b1, m_to};
        else if (m_kill > 0)  e = '{3'b001, 1'b1, 1'b1, 1'b1, 1'b1, m_to};
        else if (haz) begin
            e = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, m_to};
            stall = 1'b1;
        end else              e = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, m_to};
        exp_q.push_back(e);

        @(posedge clk);
        if (r) begin
            foreach (m_sb[i]) m_sb[i] = 1'b0;
            m_kill = 0; m_run = 0; m_to = 1'b0;
        end else begin
            if (wbv) m_sb[wbd] = 1'b0;
            if (exm && exd != 0) m_sb[exd] = 1'b1;
            if (rdr) m_kill = FC;
            else if (m_kill > 0) m_kill--;
            m_run = stall ? ((m_run < TO) ? m_run + 1 : TO) : 0;
            if (m_run == TO) m_to = 1'b1;
        end
        #1;
        cyc++;
    endtask

    task automatic nop_id(input int n);
        for (int i = 0; i < n; i++) step(0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e, g;
            e = exp_q.pop_front();
            g = '{pc_sel, IFID_write, mux_select, kill_IF, kill_DEC, hazard_timeout};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs @cycle %0d: got {pc_sel,ifid,mux,kIF,kDEC,to}=%b_%b%b%b%b%b required %b_%b%b%b%b%b",
                         cyc, g.pc_sel, g.ifid, g.mux, g.kif, g.kdec, g.to,
                         e.pc_sel, e.ifid, e.mux, e.kif, e.kdec, e.to);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = OP_NONE; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0;
        ex_mem_read = 0; wb_valid = 0; wb_rd = 0; redirect = 0; redirect_pc_sel = 0;
        @(posedge clk); #1;
        step(1, OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, OP_OP, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        nop_id(1);

        // Load-use: LOAD x5 in EX, OP x6=x5+x7 waits for writeback.
        step(0, OP_OP, 5, 7, 6, 5, 1, 0, 0, 0, 0);
        step(0, OP_OP, 5, 7, 6, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 7, 6, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 7, 6, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 7, 6, 0, 0, 1, 5, 0, 0);
        nop_id(1);

        // x0 never hazardous; operand use by opcode.
        step(0, OP_OP, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, OP_LUI, 3, 3, 4, 3, 1, 0, 0, 0, 0);
        step(0, OP_STORE, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        step(0, OP_STORE, 1, 3, 3, 0, 0, 1, 3, 0, 0);

        // WAW on x9, then same-cycle set/clear keeps x9 pending.
        step(0, OP_NONE, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        step(0, OP_OPIMM, 1, 0, 9, 0, 0, 0, 0, 0, 0);
        step(0, OP_OPIMM, 1, 0, 9, 9, 1, 1, 9, 0, 0);
        step(0, OP_OPIMM, 1, 0, 9, 0, 0, 0, 0, 0, 0);
        step(0, OP_OPIMM, 1, 0, 9, 0, 0, 1, 9, 0, 0);

        // Redirect during a stall, then a second redirect in the 2nd kill cycle.
        step(0, OP_NONE, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, OP_OP, 5, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 1, 2, 0, 0, 0, 0, 1, 3'b010);
        step(0, OP_OP, 5, 1, 2, 0, 0, 0, 0, 1, 3'b110);
        step(0, OP_OP, 5, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 1, 2, 0, 0, 1, 5, 0, 0);

        // Watchdog: x12 is never written back.
        step(0, OP_NONE, 0, 0, 0, 12, 1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, OP_OP, 12, 0, 1, 0, 0, 0, 0, 0, 0);
        nop_id(3);
        step(1, OP_OP, 12, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 12, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset mid-stall drops pending x5.
        step(0, OP_NONE, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, OP_OP, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, OP_OP, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, OP_OP, 5, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 9))
                0: op = OP_LOAD;   1: op = OP_OPIMM; 2: op = OP_AUIPC;
                3: op = OP_STORE;  4: op = OP_OP;    5: op = OP_LUI;
                6: op = OP_BRANCH; 7: op = OP_JALR;  8: op = OP_JAL;
                default: op = OP_NONE;
            endcase
            step(($urandom_range(0, 99) == 0), op,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
